spike_aer_encoder: RTL and testbench
====================================

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 SHALL have parameter N_NEURONS, default 16, number of LIF spike inputs (power of 2, 2..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter TS_WIDTH, default 8, timestamp width in bits.
REQ-004 SHALL have port clk input 1: single clock; all state on its rising edge.
REQ-005 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-006 SHALL have port fired input N_NEURONS: per-neuron spike level, one bit per LIF neuron, sampled every clk.
REQ-007 SHALL have port ts_tick input 1: timestep strobe.
REQ-008 SHALL have port aer_valid output 1: head event available.
REQ-009 SHALL have port aer_ready input 1: consumer accepts the head event.
REQ-010 SHALL have port aer_addr output log2(N_NEURONS): neuron index of the head event.
REQ-011 SHALL have port aer_ts output TS_WIDTH: timestamp of the head event.
REQ-012 SHALL have port fifo_full output 1: FIFO holds FIFO_DEPTH entries.
REQ-013 SHALL have port drop_count output 8: saturating count of lost spikes.

Function
REQ-014 SHALL update the pending register each edge: pending <= (pending & ~grant) | fired.
REQ-015 SHALL issue at most one grant per cycle, only when pending != 0 and the FIFO can accept (count < FIFO_DEPTH, or count == FIFO_DEPTH with a pop this cycle).
REQ-016 SHALL select the grant round-robin: lowest pending index >= rr_ptr, wrapping past N_NEURONS-1 to 0; rr_ptr <= granted index + 1 (mod N_NEURONS) after each grant.
REQ-017 SHALL push {addr = granted index, ts = current ts_count} into the FIFO on the granting edge.
REQ-018 SHALL pop on aer_valid & aer_ready; the FIFO SHALL support simultaneous push and pop at any occupancy, including full.
REQ-019 SHALL drive aer_valid = (count != 0); aer_addr and aer_ts SHALL hold stable while aer_valid & ~aer_ready.
REQ-020 SHALL deliver the minimum latency: fired high in cycle k -> aer_valid in cycle k+2 (empty FIFO, no contention).
REQ-021 SHALL increment drop_count, saturating at 255, on each bit where fired[i] & pending[i] & ~grant[i]; this merges the re-fire into the existing pending bit.
REQ-022 SHALL hold pending bits indefinitely while the FIFO is full; there is no timeout.
REQ-023 SHALL increment ts_count on ts_tick, wrapping 2^TS_WIDTH-1 -> 0; a grant in the same cycle as ts_tick SHALL use the pre-increment value.

Reset
REQ-024 SHALL asynchronously clear pending, rr_ptr, FIFO pointers and count, ts_count and drop_count on reset high.
REQ-025 SHALL drive aer_valid=0, fifo_full=0, drop_count=0, aer_addr=0 and aer_ts=0 while reset is high.
REQ-026 SHALL discard all queued events when reset is asserted mid-operation.
REQ-027 SHALL resume sampling fired on the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL use macro SPIKE_AER_TIMESTAMP_EN to control timestamping.
REQ-029 SHALL, when the macro is defined, implement ts_count and store TS_WIDTH timestamp bits per FIFO entry.
REQ-030 SHALL, when the macro is undefined, omit the counter and timestamp storage, tie aer_ts to 0 and ignore ts_tick; port list unchanged.

Verification
REQ-031 SHALL test basic latency: after reset, fired=16'h0010 for 1 cycle (k) -> aer_valid in k+2, aer_addr=4, aer_ts=0, drop_count=0.
REQ-032 SHALL test round-robin order: after reset, fired=16'h8009 for 1 cycle, aer_ready=1 -> events addr 0,3,15 on consecutive cycles; a next fired=16'h0003 yields 0 then 1.
REQ-033 SHALL test backpressure: aer_ready=0, fired=16'hFFFF for 1 cycle -> fifo_full after 8 pushes with addr 0..7; raise aer_ready -> 16 events total, addr 0..15 in order, none lost.
REQ-034 SHALL test the drop counter: aer_ready=0, FIFO full, fired[2] pulsed high in 300 separate cycles -> one addr-2 event once drained, drop_count=255 (saturated).
REQ-035 SHALL test timestamps (macro defined): 255 ts_tick pulses then fired[1] -> aer_ts=255; one more tick then fired[1] -> aer_ts=0 (wrap).
REQ-036 SHALL test reset mid-operation: 5 queued events plus pending bits, assert reset asynchronously between edges -> aer_valid=0 immediately; after release no stale events appear.

Source files
------------

// File: rtl/spike_aer_encoder.sv
// -----------------------------------------------------------------------------
// spike_aer_encoder
//
// Collects per-neuron spike levels from an array of LIF neurons and turns them
// into a stream of Address-Event Representation (AER) events. Each cycle at
// most one pending neuron is granted, in round-robin order, and pushed into a
// small event FIFO together with the current timestep. The consumer drains
// the FIFO through a valid/ready handshake.
//
// Ports:
//   clk         - single clock, all state on its rising edge
//   reset       - asynchronous, active-high reset
//   fired       - [N_NEURONS] spike level per neuron, sampled every clk
//   ts_tick     - timestep strobe (advances the timestamp counter)
//   aer_valid   - head event available
//   aer_ready   - consumer accepts the head event
//   aer_addr    - [log2(N_NEURONS)] neuron index of the head event
//   aer_ts      - [TS_WIDTH] timestamp of the head event
//   fifo_full   - FIFO holds FIFO_DEPTH entries
//   drop_count  - [8] saturating count of spikes merged into a still-pending bit
//
// Configuration macro:
//   SPIKE_AER_TIMESTAMP_EN - when defined, a TS_WIDTH-bit timestep counter is
//   kept and stored with every event. When undefined, the counter and the
//   timestamp storage are omitted, aer_ts reads 0 and ts_tick is ignored.
// -----------------------------------------------------------------------------
module spike_aer_encoder #(
  parameter int N_NEURONS  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_NEURONS-1:0]         fired,
  input  logic                         ts_tick,
  output logic                         aer_valid,
  input  logic                         aer_ready,
  output logic [$clog2(N_NEURONS)-1:0] aer_addr,
  output logic [TS_WIDTH-1:0]          aer_ts,
  output logic                         fifo_full,
  output logic [7:0]                   drop_count
);

  localparam int AW = $clog2(N_NEURONS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [AW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [7:0]           drop_count_q, drop_count_d;
  logic [AW-1:0]        mem_addr_q [FIFO_DEPTH];

  logic                 pop_s;
  logic                 can_push_s;
  logic                 found_s;
  logic                 push_s;
  logic [AW-1:0]        grant_idx_s;
  logic [AW-1:0]        cand_s;
  logic [N_NEURONS-1:0] grant_vec_s;
  logic [N_NEURONS-1:0] drop_bits_s;
  logic [8:0]           drop_sum_s;

  assign aer_valid  = (count_q != '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign aer_addr   = mem_addr_q[rd_ptr_q];
  assign drop_count = drop_count_q;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push.
  assign pop_s      = aer_valid & aer_ready;
  assign can_push_s = (count_q != CW'(FIFO_DEPTH)) | pop_s;
  assign push_s     = found_s & can_push_s;

  // Round-robin search: first pending index at or after rr_ptr, wrapping.
  // AW-bit addition wraps naturally because N_NEURONS is a power of two.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      cand_s = rr_ptr_q + AW'(i);
      if (!found_s && pending_q[cand_s]) begin
        found_s     = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Pending set, round-robin pointer and drop accounting.
  always_comb begin
    grant_vec_s = '0;
    if (push_s) begin
      grant_vec_s[grant_idx_s] = 1'b1;
      rr_ptr_d                 = grant_idx_s + AW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    pending_d = (pending_q & ~grant_vec_s) | fired;
    // A re-fire on a bit that stays pending is merged and counted as lost.
    drop_bits_s = fired & pending_q & ~grant_vec_s;
    drop_sum_s  = {1'b0, drop_count_q};
    for (int i = 0; i < N_NEURONS; i++) begin
      if (drop_bits_s[i]) begin
        drop_sum_s = drop_sum_s + 9'd1;
      end else begin
        drop_sum_s = drop_sum_s;
      end
    end
    if (drop_sum_s > 9'd255) begin
      drop_count_d = 8'd255;
    end else begin
      drop_count_d = drop_sum_s[7:0];
    end
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_count_q <= 8'd0;
    end else begin
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Event address storage; cleared on reset so the head reads 0 when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_addr_q[wr_ptr_q] <= grant_idx_s;
    end
  end

`ifdef SPIKE_AER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_count_q, ts_count_d;
  logic [TS_WIDTH-1:0] mem_ts_q [FIFO_DEPTH];

  assign aer_ts = mem_ts_q[rd_ptr_q];

  // Timestep counter, wraps at 2^TS_WIDTH.
  always_comb begin
    if (ts_tick) begin
      ts_count_d = ts_count_q + TS_WIDTH'(1);
    end else begin
      ts_count_d = ts_count_q;
    end
  end

  // Timestep counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_count_q <= '0;
    end else begin
      ts_count_q <= ts_count_d;
    end
  end

  // Timestamp storage; a grant stores the pre-increment counter value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_ts_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_ts_q[wr_ptr_q] <= ts_count_q;
    end
  end
`else
  logic unused_ts_tick_s;
  assign unused_ts_tick_s = ts_tick;
  assign aer_ts           = '0;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// -----------------------------------------------------------------------------
// tb_spike_aer_encoder
//
// Directed, self-checking bench for spike_aer_encoder with default parameters
// (16 neurons, 8-entry FIFO, 8-bit timestamps). Each scenario is a task with
// its own inline comparisons; expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_spike_aer_encoder;

  logic        clk;
  logic        reset;
  logic [15:0] fired;
  logic        ts_tick;
  logic        aer_valid;
  logic        aer_ready;
  logic [3:0]  aer_addr;
  logic [7:0]  aer_ts;
  logic        fifo_full;
  logic [7:0]  drop_count;

  int n_checks;
  int n_fail;

  spike_aer_encoder #(
    .N_NEURONS (16),
    .FIFO_DEPTH(8),
    .TS_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fired     (fired),
    .ts_tick   (ts_tick),
    .aer_valid (aer_valid),
    .aer_ready (aer_ready),
    .aer_addr  (aer_addr),
    .aer_ts    (aer_ts),
    .fifo_full (fifo_full),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    fired     = 16'h0000;
    ts_tick   = 1'b0;
    aer_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    fired     = 16'h0000;
    ts_tick   = 1'b0;
    aer_ready = 1'b0;
    step();
    n_checks++; if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", aer_valid); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", fifo_full); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    n_checks++; if (aer_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", aer_addr); end
    n_checks++; if (aer_ts !== 8'd0) begin n_fail++; $display("FAIL reset_ts: got %0d expected 0", aer_ts); end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    fired = 16'h0010;            // cycle k
    step();
    fired = 16'h0000;            // cycle k+1
    n_checks++; if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid: got %0b expected 0", aer_valid); end
    step();                      // cycle k+2
    n_checks++; if (aer_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %0b expected 1", aer_valid); end
    n_checks++; if (aer_addr !== 4'd4) begin n_fail++; $display("FAIL lat_addr: got %0d expected 4", aer_addr); end
    n_checks++; if (aer_ts !== 8'd0) begin n_fail++; $display("FAIL lat_ts: got %0d expected 0", aer_ts); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL lat_drop: got %0d expected 0", drop_count); end
    // Holding with ready low keeps the head stable.
    step();
    n_checks++; if (aer_valid !== 1'b1 || aer_addr !== 4'd4) begin n_fail++; $display("FAIL lat_hold: got valid=%0b addr=%0d expected valid=1 addr=4", aer_valid, aer_addr); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_a [5];
    exp_a[0] = 4'd0; exp_a[1] = 4'd3; exp_a[2] = 4'd15; exp_a[3] = 4'd0; exp_a[4] = 4'd1;
    do_reset();
    aer_ready = 1'b1;
    fired = 16'h8009;
    step();
    fired = 16'h0000;
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (aer_valid !== 1'b1 || aer_addr !== exp_a[i]) begin n_fail++; $display("FAIL rr_first[%0d]: got valid=%0b addr=%0d expected valid=1 addr=%0d", i, aer_valid, aer_addr, exp_a[i]); end
      step();
    end
    n_checks++; if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL rr_first_empty: got %0b expected 0", aer_valid); end
    fired = 16'h0003;
    step();
    fired = 16'h0000;
    step();
    for (int i = 3; i < 5; i++) begin
      n_checks++; if (aer_valid !== 1'b1 || aer_addr !== exp_a[i]) begin n_fail++; $display("FAIL rr_second[%0d]: got valid=%0b addr=%0d expected valid=1 addr=%0d", i, aer_valid, aer_addr, exp_a[i]); end
      step();
    end
    n_checks++; if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL rr_second_empty: got %0b expected 0", aer_valid); end
  endtask

  task automatic test_backpressure();
    int got;
    do_reset();
    fired = 16'hFFFF;
    step();
    fired = 16'h0000;
    for (int i = 0; i < 7; i++) step();
    // Seven pushes so far; not yet full.
    n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL bp_not_full: got %0b expected 0", fifo_full); end
    step();
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL bp_full: got %0b expected 1", fifo_full); end
    n_checks++; if (aer_addr !== 4'd0) begin n_fail++; $display("FAIL bp_head: got %0d expected 0", aer_addr); end
    step();
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL bp_stay_full: got %0b expected 1", fifo_full); end
    aer_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 16; c++) begin
      if (aer_valid) begin
        n_checks++; if (aer_addr !== got[3:0]) begin n_fail++; $display("FAIL bp_order[%0d]: got %0d expected %0d", got, aer_addr, got); end
        got++;
      end
      step();
    end
    n_checks++; if (got !== 16) begin n_fail++; $display("FAIL bp_total: got %0d expected 16", got); end
    n_checks++; if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %0b expected 0", aer_valid); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL bp_drop: got %0d expected 0", drop_count); end
  endtask

  task automatic test_drop_counter();
    int got;
    logic [3:0] exp_addr;
    do_reset();
    fired = 16'hFF00;
    step();
    fired = 16'h0000;
    for (int i = 0; i < 9; i++) step();
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL drop_setup_full: got %0b expected 1", fifo_full); end
    for (int p = 0; p < 300; p++) begin
      fired = 16'h0004;
      step();
      fired = 16'h0000;
      step();
    end
    n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL drop_saturate: got %0d expected 255", drop_count); end
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL drop_still_full: got %0b expected 1", fifo_full); end
    aer_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (aer_valid) begin
        exp_addr = (got < 8) ? 4'(8 + got) : 4'd2;
        n_checks++; if (aer_addr !== exp_addr) begin n_fail++; $display("FAIL drop_order[%0d]: got %0d expected %0d", got, aer_addr, exp_addr); end
        got++;
      end
      step();
    end
    n_checks++; if (got !== 9) begin n_fail++; $display("FAIL drop_events: got %0d expected 9", got); end
    n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL drop_hold: got %0d expected 255", drop_count); end
  endtask

  task automatic test_timestamp();
    logic [7:0] exp_ts;
    do_reset();
    aer_ready = 1'b1;
    ts_tick = 1'b1;
    for (int i = 0; i < 255; i++) step();
    ts_tick = 1'b0;
    fired = 16'h0002;
    step();
    fired = 16'h0000;
    step();
`ifdef SPIKE_AER_TIMESTAMP_EN
    exp_ts = 8'd255;
`else
    exp_ts = 8'd0;
`endif
    n_checks++; if (aer_valid !== 1'b1 || aer_addr !== 4'd1) begin n_fail++; $display("FAIL ts_evt1: got valid=%0b addr=%0d expected valid=1 addr=1", aer_valid, aer_addr); end
    n_checks++; if (aer_ts !== exp_ts) begin n_fail++; $display("FAIL ts_max: got %0d expected %0d", aer_ts, exp_ts); end
    step();
    ts_tick = 1'b1;
    step();
    ts_tick = 1'b0;
    fired = 16'h0002;
    step();
    fired = 16'h0000;
    step();
    n_checks++; if (aer_valid !== 1'b1 || aer_addr !== 4'd1) begin n_fail++; $display("FAIL ts_evt2: got valid=%0b addr=%0d expected valid=1 addr=1", aer_valid, aer_addr); end
    n_checks++; if (aer_ts !== 8'd0) begin n_fail++; $display("FAIL ts_wrap: got %0d expected 0", aer_ts); end
    step();
  endtask

  task automatic test_reset_mid();
    int stale;
    do_reset();
    fired = 16'h001F;
    step();
    fired = 16'h0000;
    for (int i = 0; i < 5; i++) step();
    n_checks++; if (aer_valid !== 1'b1 || aer_addr !== 4'd0) begin n_fail++; $display("FAIL rmid_queued: got valid=%0b addr=%0d expected valid=1 addr=0", aer_valid, aer_addr); end
    fired = 16'h0300;
    step();
    fired = 16'h0000;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b expected 0", aer_valid); end
    n_checks++; if (aer_addr !== 4'd0 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL rmid_outs: got addr=%0d full=%0b expected addr=0 full=0", aer_addr, fifo_full); end
    step();
    reset     = 1'b0;
    aer_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      if (aer_valid) stale++;
      step();
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rmid_stale: got %0d stale cycles expected 0", stale); end
    fired = 16'h0040;
    step();
    fired = 16'h0000;
    step();
    n_checks++; if (aer_valid !== 1'b1 || aer_addr !== 4'd6) begin n_fail++; $display("FAIL rmid_resume: got valid=%0b addr=%0d expected valid=1 addr=6", aer_valid, aer_addr); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    fired     = 16'h0000;
    ts_tick   = 1'b0;
    aer_ready = 1'b0;
    test_reset();
    test_latency();
    test_round_robin();
    test_backpressure();
    test_drop_counter();
    test_timestamp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
